// File: rtl/triumph_riscv_defines.sv
// triumph_riscv_defines: shared encodings for the memory arbiter.
// Provides the arbiter FSM state type, the transaction owner type and the
// width of the data-streak counter.
package triumph_riscv_defines;
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RSP  = 2'd2
    } arb_state_t;
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;
    localparam int STREAK_W = 4;
endpackage

// File: rtl/triumph_arb_prio.sv
// triumph_arb_prio: data-first priority select with a fetch anti-starvation override.
// Ports: if_req/d_req - pending requests; streak - consecutive contested data wins;
//        gnt - one-hot grant vector indexed by owner_t (at most one bit set).
module triumph_arb_prio
    import triumph_riscv_defines::*;
#(
    parameter int MAX_STREAK = 4
) (
    input  logic                if_req,
    input  logic                d_req,
    input  logic [STREAK_W-1:0] streak,
    output logic [1:0]          gnt
);
    localparam logic [STREAK_W-1:0] MAX = STREAK_W'(MAX_STREAK);
    always_comb begin
        gnt        = '0;
        gnt[OWN_D] = d_req && (!if_req || streak < MAX);
        gnt[OWN_IF] = if_req && !gnt[OWN_D];
    end
endmodule

// File: rtl/triumph_mem_arbiter.sv
// triumph_mem_arbiter: shares one memory port between fetch and data requesters.
// Ports: clk_i/rst_ni - clock and async active-low reset;
//        if_* - fetch request/grant/response; d_* - load/store request/grant/response;
//        mem_* - single-outstanding memory port; busy_o - transaction in flight;
//        proto_err_o - pulse on a memory response nobody is waiting for.
module triumph_mem_arbiter
    import triumph_riscv_defines::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [DATA_W/8-1:0] d_be_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    output logic                d_gnt_o,
    output logic                d_rvalid_o,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                busy_o,
    output logic                proto_err_o
);
    localparam logic [STREAK_W-1:0] MAX = STREAK_W'(MAX_STREAK);
    arb_state_t          state;
    owner_t              owner;
    logic [STREAK_W-1:0] streak;
    logic [1:0]          gnt;
    logic                idle;
    logic                rsp_ok;
    triumph_arb_prio #(.MAX_STREAK(MAX_STREAK)) u_prio (
        .if_req (if_req_i),
        .d_req  (d_req_i),
        .streak (streak),
        .gnt    (gnt)
    );
    // Grants are suppressed while reset is asserted so every output reads 0.
    assign idle     = (state == ARB_IDLE) && rst_ni;
    assign if_gnt_o = idle && gnt[OWN_IF];
    assign d_gnt_o  = idle && gnt[OWN_D];
    // A response is only legal once the memory has accepted the request,
    // which includes the same cycle as the accept.
    assign rsp_ok      = mem_rvalid_i && (state == ARB_RSP || (state == ARB_REQ && mem_gnt_i));
    assign if_rvalid_o = rsp_ok && owner == OWN_IF;
    assign d_rvalid_o  = rsp_ok && owner == OWN_D;
    assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    assign d_rdata_o   = d_rvalid_o ? mem_rdata_i : '0;
    assign proto_err_o = rst_ni && mem_rvalid_i && !rsp_ok;
    assign mem_req_o   = state == ARB_REQ;
    assign busy_o      = state != ARB_IDLE;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ARB_IDLE;
            owner       <= OWN_IF;
            streak      <= '0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            case (state)
                ARB_IDLE: if (if_gnt_o || d_gnt_o) begin
                    state       <= ARB_REQ;
                    owner       <= d_gnt_o ? OWN_D : OWN_IF;
                    mem_we_o    <= d_gnt_o && d_we_i;
                    mem_be_o    <= d_gnt_o ? d_be_i : '1;
                    mem_addr_o  <= d_gnt_o ? d_addr_i : if_addr_i;
                    mem_wdata_o <= d_gnt_o ? d_wdata_i : '0;
                    // Only contested data wins extend the streak; it saturates.
                    streak      <= (d_gnt_o && if_req_i) ? ((streak == MAX) ? streak : streak + 1'b1) : '0;
                end
                ARB_REQ:  if (mem_gnt_i) state <= mem_rvalid_i ? ARB_IDLE : ARB_RSP;
                ARB_RSP:  if (mem_rvalid_i) state <= ARB_IDLE;
                default:  state <= ARB_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_triumph_mem_arbiter.sv
// tb_triumph_mem_arbiter: directed scoreboard bench for the fetch/data memory arbiter.
module tb_triumph_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [3:0]  d_be = '0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        busy, proto_err;
    int          n_cmp = 0;
    int          n_err = 0;

    typedef struct {
        logic        own;
        logic        we;
        logic [31:0] data;
    } exp_t;
    exp_t q[$];

    triumph_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STREAK(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr),
        .d_wdata_i(d_wdata), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata), .busy_o(busy), .proto_err_o(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Pops the scoreboard whenever either requester sees a response.
    task automatic observe();
        exp_t e;
        if (if_rvalid || d_rvalid) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL sb_underflow observed=rvalid expected=none");
            end else begin
                e = q.pop_front();
                chk("rsp_owner", d_rvalid, e.own);
                chk("rsp_single", if_rvalid & d_rvalid, 0);
                if (!e.we) chk("rsp_data", e.own ? d_rdata : if_rdata, e.data);
                chk("rsp_other_zero", e.own ? if_rdata : d_rdata, 0);
            end
        end
    endtask

    initial begin
        #1;
        chk("reset_outputs", {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, mem_req,
                              mem_we, mem_be, mem_addr, mem_wdata, busy, proto_err}, 0);
        tick(); rst_n = 1'b1;
        // Single fetch with zero-wait memory.
        tick(); if_req = 1'b1; if_addr = 32'h100; #1;
        chk("fetch_gnt", if_gnt, 1); chk("fetch_no_dgnt", d_gnt, 0);
        q.push_back('{1'b0, 1'b0, 32'hDEADBEEF});
        tick(); if_req = 1'b0; mem_gnt = 1'b1; #1;
        chk("fetch_mem_req", mem_req, 1); chk("fetch_mem_we", mem_we, 0);
        chk("fetch_mem_be", mem_be, 4'hF); chk("fetch_mem_addr", mem_addr, 32'h100);
        tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF; #1;
        chk("fetch_rvalid", if_rvalid, 1); chk("fetch_rsp_req_low", mem_req, 0); observe();
        tick(); mem_rvalid = 1'b0; #1;
        chk("fetch_idle", busy, 0);
        // Store with three stall cycles.
        tick(); d_req = 1'b1; d_we = 1'b1; d_be = 4'h3; d_addr = 32'h2000; d_wdata = 32'h12345678; #1;
        chk("store_gnt", d_gnt, 1);
        q.push_back('{1'b1, 1'b1, 32'h0});
        tick(); d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_wdata = 32'h0; #1;
        chk("store_mem_we", mem_we, 1); chk("store_mem_be", mem_be, 4'h3);
        chk("store_mem_addr", mem_addr, 32'h2000);
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk("store_stall_req", mem_req, 1); chk("store_stall_wdata", mem_wdata, 32'h12345678);
        end
        tick(); mem_gnt = 1'b1; #1;
        chk("store_gnt_wdata", mem_wdata, 32'h12345678);
        tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; #1;
        chk("store_rvalid", d_rvalid, 1); observe();
        tick(); mem_rvalid = 1'b0; #1;
        chk("store_rvalid_once", d_rvalid, 0);
        // Both requesters held: anti-starvation pattern D,D,D,D,IF repeating.
        for (int i = 0; i < 10; i++) begin
            tick(); mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h400; d_req = 1'b1; d_addr = 32'h3000; #1;
            chk("streak_dgnt", d_gnt, (i % 5) != 4);
            chk("streak_ifgnt", if_gnt, (i % 5) == 4);
            q.push_back('{(i % 5) != 4, 1'b0, 32'hA000_0000 + 32'(i)});
            tick(); mem_gnt = 1'b1; #1;
            chk("busy_no_gnt", {if_gnt, d_gnt}, 0);
            tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA000_0000 + 32'(i); #1;
            observe();
        end
        tick(); mem_rvalid = 1'b0; if_req = 1'b0; d_req = 1'b0;
        // Grant and response in the same cycle.
        tick(); d_req = 1'b1; d_addr = 32'h3000; #1;
        chk("fast_gnt", d_gnt, 1);
        q.push_back('{1'b1, 1'b0, 32'hCAFEF00D});
        tick(); d_req = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D; #1;
        chk("fast_rvalid", d_rvalid, 1); chk("fast_no_perr", proto_err, 0); observe();
        tick(); mem_gnt = 1'b0; mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h500; #1;
        chk("fast_idle", busy, 0); chk("fast_next_gnt", if_gnt, 1);
        q.push_back('{1'b0, 1'b0, 32'h11111111});
        tick(); if_req = 1'b0; mem_gnt = 1'b1; #1;
        chk("fast2_addr", mem_addr, 32'h500);
        tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h11111111; #1;
        chk("fast2_rvalid", if_rvalid, 1); observe();
        tick(); mem_rvalid = 1'b0;
        // Spurious response while idle.
        tick(); mem_rvalid = 1'b1; mem_rdata = 32'h55; #1;
        chk("spur_perr", proto_err, 1); chk("spur_no_rvalid", {if_rvalid, d_rvalid}, 0);
        chk("spur_idle", busy, 0);
        tick(); mem_rvalid = 1'b0; #1;
        chk("spur_perr_pulse", proto_err, 0);
        // Spurious response in REQ without gnt.
        tick(); if_req = 1'b1; if_addr = 32'h600; #1;
        q.push_back('{1'b0, 1'b0, 32'h66});
        tick(); if_req = 1'b0; mem_rvalid = 1'b1; #1;
        chk("req_spur_perr", proto_err, 1); chk("req_spur_no_rvalid", if_rvalid, 0);
        tick(); mem_rvalid = 1'b0; mem_gnt = 1'b1; #1;
        tick(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h66; #1;
        chk("req_spur_rvalid", if_rvalid, 1); observe();
        tick(); mem_rvalid = 1'b0;
        // Reset while a load is waiting for its response.
        tick(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700; #1;
        chk("rst_load_gnt", d_gnt, 1);
        tick(); d_req = 1'b0; mem_gnt = 1'b1; #1;
        tick(); mem_gnt = 1'b0; #1;
        chk("rst_in_rsp", busy, 1);
        rst_n = 1'b0; #1;
        chk("rst_mid_outputs", {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, mem_req,
                                mem_we, mem_be, mem_addr, mem_wdata, busy, proto_err}, 0);
        tick(); rst_n = 1'b1;
        tick(); mem_rvalid = 1'b1; mem_rdata = 32'h77; #1;
        chk("late_perr", proto_err, 1); chk("late_no_drvalid", d_rvalid, 0);
        tick(); mem_rvalid = 1'b0; #1;
        chk("sb_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/triumph_mem_arbiter.md
Name: triumph_mem_arbiter

Overview:
- Shares a single external memory port between the instruction-fetch requester and the data (load/store) requester.
- Issues one transaction at a time and routes the response back to its owner.
- Priority goes to data accesses, with a bounded-streak guard so fetch cannot starve.
- Sits between the fetch/LSU stages and the unified memory interface; carries the store traffic driven by the pipeline controller's dcache write enable.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width; byte enables are DATA_W/8 bits
MAX_STREAK, 4, consecutive contested data wins before fetch is forced through; legal range 1..15

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
if_req_i  in  1  fetch request; held with if_addr_i stable until if_gnt_o
if_addr_i  in  ADDR_W  fetch address
if_gnt_o  out  1  fetch request accepted (one-cycle pulse)
if_rvalid_o  out  1  fetch read data valid (one-cycle pulse)
if_rdata_o  out  DATA_W  fetch read data
d_req_i  in  1  data request; held with attributes stable until d_gnt_o
d_we_i  in  1  1 = store, 0 = load
d_be_i  in  DATA_W/8  byte enables
d_addr_i  in  ADDR_W  data address
d_wdata_i  in  DATA_W  store data
d_gnt_o  out  1  data request accepted (one-cycle pulse)
d_rvalid_o  out  1  load data / store completion valid (one-cycle pulse)
d_rdata_o  out  DATA_W  load data
mem_req_o  out  1  memory request
mem_we_o  out  1  memory write
mem_be_o  out  DATA_W/8  memory byte enables
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_gnt_i  in  1  memory accepted the request
mem_rvalid_i  in  1  memory response (reads and writes)
mem_rdata_i  in  DATA_W  memory read data
busy_o  out  1  transaction in flight
proto_err_o  out  1  one-cycle pulse on an unexpected mem_rvalid_i

Behaviour:
- FSM states: IDLE, REQ, RSP.
- Reset (asynchronous, rst_ni low):
  - state = IDLE; owner = fetch; streak = 0.
  - All outputs 0, including mem_* attribute registers.
  - Any in-flight transaction is abandoned; no rvalid is delivered after reset.
- IDLE, arbitration (combinational):
  - Only d_req_i set: grant data.
  - Only if_req_i set: grant fetch.
  - Both set: grant data if streak < MAX_STREAK, otherwise grant fetch.
  - The winner's gnt_o is asserted in the same cycle. Both gnt_o are never high together.
- IDLE, at the accepting edge:
  - Capture owner, we, be, addr, wdata into registers. Fetch forces we = 0 and be = all ones.
  - Go to REQ.
  - Streak update: contested data win -> streak + 1; fetch win -> 0; uncontested data win -> 0.
- REQ:
  - mem_req_o = 1 and mem_* are driven from registers, held stable until mem_gnt_i.
  - On mem_gnt_i, go to RSP.
  - mem_gnt_i and mem_rvalid_i in the same cycle: deliver the response and go directly to IDLE.
- RSP:
  - mem_req_o = 0.
  - On mem_rvalid_i: the owner's rvalid_o = 1 in the same cycle. rdata_o passes mem_rdata_i through combinationally; the non-owner's rdata_o is 0.
  - Then go to IDLE.
  - Stores also receive a completion via d_rvalid_o; d_rdata_o is don't-care for stores.
- Latency: accept in cycle N, mem_req_o from N+1. With a zero-wait memory (gnt in N+1, rvalid in N+2), the next accept can happen in N+3.
- busy_o = (state != IDLE).
- mem_rvalid_i in IDLE, or in REQ without mem_gnt_i: ignored, proto_err_o pulses, no rvalid is forwarded.
- Requests arriving while not in IDLE get no gnt; requesters keep holding.
- The streak counter saturates at MAX_STREAK and never wraps.

Decomposition:
- Shared package (triumph_riscv_defines): FSM state encodings ARB_IDLE/ARB_REQ/ARB_RSP and owner encodings OWN_IF/OWN_D.
- One natural sub-module: triumph_arb_prio. It is combinational fixed-priority-with-streak-override selection, taking both reqs and streak as inputs and producing the grant vector. Counter, FSM and registers stay in the top.

Test Plan:
- Reset mid-transaction: d_req load accepted, rst_ni low while in RSP -> all outputs 0 immediately; after release, a late mem_rvalid_i pulses proto_err_o with no d_rvalid_o.
- Single fetch, addr 0x100, memory returns 0xDEADBEEF one cycle after gnt -> if_gnt_o in cycle 0, mem_req_o with we = 0 and be = 0xF in cycle 1, if_rvalid_o with 0xDEADBEEF in cycle 2.
- Store addr 0x2000, wdata 0x12345678, be 0x3 -> mem_we_o = 1, mem_be_o = 0x3, mem_wdata_o held stable through 3 stall cycles of mem_gnt_i = 0; d_rvalid_o pulses once.
- Both requesters held continuously, MAX_STREAK = 4 -> grant sequence D, D, D, D, IF, D, D, D, D, IF.
- mem_gnt_i and mem_rvalid_i asserted in the same cycle for a load -> d_rvalid_o that cycle, FSM back in IDLE, next grant one cycle later.
- Spurious mem_rvalid_i in IDLE -> proto_err_o high for 1 cycle; no rvalid output; state unchanged.
